// File: rtl/token_window_counter.sv
// token_window_counter
// Counts '1' tokens over fixed windows of WINDOW enabled samples and hands
// each window total to a one-entry valid/ready output register. A result that
// completes while the previous one is still unaccepted is dropped and latched
// into the sticky overrun flag. Windowing never stalls on backpressure.
module token_window_counter #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             clr_ovr,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overrun
);

    localparam int unsigned IDX_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] acc;

    logic             win_end_c;
    logic             xfer_c;
    logic             drop_c;
    logic [CNT_W-1:0] result_c;

    // Window-end detection, running total including this sample, handshake and drop
    always_comb begin
        win_end_c = 1'b0;
        xfer_c    = 1'b0;
        drop_c    = 1'b0;
        result_c  = acc + CNT_W'(a);
        win_end_c = en && (idx == LAST_IDX);
        xfer_c    = (state == FULL) && count_ready;
        drop_c    = win_end_c && (state == FULL) && !count_ready;
    end

    // Sample index and accumulator; frozen when en=0, restart cleanly after window end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
            acc <= '0;
        end else if (en) begin
            if (win_end_c) begin
                idx <= '0;
                acc <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
                acc <= result_c;
            end
        end
    end

    // One-entry output register: load on window end when empty or being drained
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            count <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (win_end_c) begin
                        count <= result_c;
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (xfer_c && win_end_c) begin
                        count <= result_c;
                    end else if (xfer_c) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Sticky overrun: a drop in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (drop_c) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

    assign count_valid = (state == FULL);

endmodule

// File: tb/tb_token_window_counter.sv
// Self-checking bench for token_window_counter (WINDOW=4): directed scenarios
// with hand-derived expectations, then randomized traffic against a
// window-level reference model.
module tb_token_window_counter;

    localparam int unsigned WIN   = 4;
    localparam int unsigned CNT_W = $clog2(WIN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             a;
    logic             clr_ovr;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             count_ready;
    logic             overrun;

    int vectors    = 0;
    int miscompares = 0;

    // reference model: samples seen in current window, ones seen, output slot
    int m_n     = 0;
    int m_ones  = 0;
    int m_count = 0;
    bit m_valid = 0;
    bit m_ovr   = 0;

    token_window_counter #(.WINDOW(WIN)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .a           (a),
        .clr_ovr     (clr_ovr),
        .count       (count),
        .count_valid (count_valid),
        .count_ready (count_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_n = 0; m_ones = 0; m_count = 0; m_valid = 0; m_ovr = 0;
    endtask

    // drive one cycle, advance the model on the edge, settle 1 time unit after
    task automatic step(input logic e, input logic s, input logic r, input logic c);
        bit hs, wend, drop;
        int res;
        en = e; a = s; count_ready = r; clr_ovr = c;
        @(posedge clk);
        hs = m_valid && r; wend = 0; drop = 0; res = 0;
        if (e) begin
            m_ones += int'(s);
            m_n++;
            if (m_n == int'(WIN)) begin
                wend = 1; res = m_ones; m_ones = 0; m_n = 0;
            end
        end
        if (wend) begin
            if (!m_valid || hs) begin m_count = res; m_valid = 1; end
            else drop = 1;
        end else if (hs) begin
            m_valid = 0;
        end
        if (drop) m_ovr = 1;
        else if (c) m_ovr = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 0; a = 0; count_ready = 0; clr_ovr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++; if (count_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", count_valid); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_full_window();
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
        vectors++; if (count_valid !== 1'b0) begin miscompares++; $display("FAIL full_early_valid got=%b exp=0", count_valid); end
        step(1, 1, 1, 0);
        vectors++; if (count_valid !== 1'b1) begin miscompares++; $display("FAIL full_valid got=%b exp=1", count_valid); end
        vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_count got=%0d exp=4", count); end
        step(0, 0, 1, 0);
        vectors++; if (count_valid !== 1'b0) begin miscompares++; $display("FAIL full_one_cycle got=%b exp=0", count_valid); end
    endtask

    task automatic test_halved_stream();
        logic [3:0] pat1 = 4'b0010;
        logic [3:0] pat2 = 4'b1010;
        for (int i = 0; i < 4; i++) step(1, pat1[i], 0, 0);
        vectors++; if (count !== 3'd1 || count_valid !== 1'b1) begin miscompares++; $display("FAIL halved_first got=%0d/%b exp=1/1", count, count_valid); end
        for (int i = 0; i < 3; i++) begin
            step(1, pat2[i], 1, 0);
            vectors++; if (count_valid !== 1'b0) begin miscompares++; $display("FAIL halved_gap%0d got=%b exp=0", i, count_valid); end
        end
        step(1, pat2[3], 1, 0);
        vectors++; if (count !== 3'd2 || count_valid !== 1'b1) begin miscompares++; $display("FAIL halved_second got=%0d/%b exp=2/1", count, count_valid); end
        step(0, 0, 1, 0);
    endtask

    task automatic test_sample_gaps();
        logic [5:0] enp = 6'b110101;
        for (int i = 0; i < 5; i++) begin
            step(enp[i], 1, 1, 0);
            vectors++; if (count_valid !== 1'b0) begin miscompares++; $display("FAIL gaps_early%0d got=%b exp=0", i, count_valid); end
        end
        step(enp[5], 1, 1, 0);
        vectors++; if (count !== 3'd4 || count_valid !== 1'b1) begin miscompares++; $display("FAIL gaps_result got=%0d/%b exp=4/1", count, count_valid); end
        step(0, 1, 1, 0);
        vectors++; if (count_valid !== 1'b0) begin miscompares++; $display("FAIL gaps_drain got=%b exp=0", count_valid); end
    endtask

    task automatic test_overrun();
        logic [3:0] p1 = 4'b1011;
        logic [3:0] p2 = 4'b1000;
        for (int i = 0; i < 4; i++) step(1, p1[i], 0, 0);
        vectors++; if (count !== 3'd3 || overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_hold got=%0d/%b exp=3/0", count, overrun); end
        for (int i = 0; i < 4; i++) step(1, p2[i], 0, 0);
        vectors++; if (count !== 3'd3 || count_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_kept got=%0d/%b exp=3/1", count, count_valid); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        step(0, 0, 1, 0);
        vectors++; if (count_valid !== 1'b0 || overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_accept got=%b/%b exp=0/1", count_valid, overrun); end
        step(0, 0, 0, 1);
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        // drop and clear on the same edge: set wins
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        vectors++; if (overrun !== 1'b1 || count !== 3'd4) begin miscompares++; $display("FAIL ovr_set_wins got=%b/%0d exp=1/4", overrun, count); end
        step(0, 0, 1, 1);
        vectors++; if (overrun !== 1'b0 || count_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_final got=%b/%b exp=0/0", overrun, count_valid); end
    endtask

    task automatic test_accept_and_load();
        logic [3:0] p1 = 4'b0111;
        for (int i = 0; i < 4; i++) step(1, p1[i], 0, 0);
        vectors++; if (count !== 3'd3 || count_valid !== 1'b1) begin miscompares++; $display("FAIL acc_first got=%0d/%b exp=3/1", count, count_valid); end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        vectors++; if (count !== 3'd1 || count_valid !== 1'b1 || overrun !== 1'b0) begin miscompares++; $display("FAIL acc_reload got=%0d/%b/%b exp=1/1/0", count, count_valid, overrun); end
        step(0, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        vectors++; if (count_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre got=%b exp=1", count_valid); end
        #2 rst = 1'b0;
        #1;
        model_reset();
        vectors++; if (count !== 3'd0 || count_valid !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL arst_immediate got=%0d/%b/%b exp=0/0/0", count, count_valid, overrun); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        vectors++; if (count !== 3'd4 || count_valid !== 1'b1) begin miscompares++; $display("FAIL arst_after got=%0d/%b exp=4/1", count, count_valid); end
        step(0, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
            vectors++; if (count_valid !== m_valid) begin miscompares++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, count_valid, m_valid); end
            vectors++; if (overrun !== m_ovr) begin miscompares++; $display("FAIL rand_overrun cyc=%0d got=%b exp=%b", i, overrun, m_ovr); end
            vectors++; if (int'(count) != m_count) begin miscompares++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, count, m_count); end
        end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_halved_stream();
        test_sample_gaps();
        test_overrun();
        test_accept_and_load();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
